uart_rx: RTL

UART serial receiver, the downstream partner of the FSM-based UART transmitter. It samples the serial line with an external oversampling tick (16× baud), validates the start bit at mid-bit, deserialises LSB-first data and checks the stop bit. It delivers each received word with a single-cycle valid strobe. In the lab loopback setup it sits on the far end of the `TxD` wire, clocked from the same 100 MHz `clk` and fed by a baud generator configured for 16× the transmitter rate.

---
 rtl/uart_rx.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchronised RxD, OVERSAMPLE ticks per bit, mid-bit
// start validation, LSB-first deserialisation and stop-bit framing check.
module uart_rx #(
  parameter int DATA_WIDTH = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx_en,
  input  logic                  RxD,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  frame_err,
  output logic                  rx_busy
);

  localparam int TW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0] TICK_HALF = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_WIDTH - 1);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] START = 3'd1;
  localparam logic [2:0] DATA  = 3'd2;
  localparam logic [2:0] STOP  = 3'd3;
  localparam logic [2:0] BREAK = 3'd4;

  logic [1:0]            sync_q, sync_d;
  logic [2:0]            state_q, state_d;
  logic [TW-1:0]         tick_cnt_q, tick_cnt_d;
  logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
  logic                  rx_valid_q, rx_valid_d;
  logic                  frame_err_q, frame_err_d;
  logic                  rxd_s;
  logic [DATA_WIDTH:0]   shift_ext;

  assign rxd_s     = sync_q[1];
  assign sync_d    = {sync_q[0], RxD};
  assign shift_ext = {rxd_s, shift_q};

  always_comb begin
    state_d     = state_q;
    tick_cnt_d  = tick_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    frame_err_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (rx_en && !rxd_s) begin
          state_d    = START;
          tick_cnt_d = '0;
        end
      end

      START: begin
        if (rx_en) begin
          if (tick_cnt_q == TICK_HALF) begin
            // Line must still be low at mid start bit, otherwise it was a glitch.
            if (!rxd_s) begin
              state_d    = DATA;
              tick_cnt_d = '0;
              bit_cnt_d  = '0;
            end else begin
              state_d = IDLE;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end
      end

      DATA: begin
        if (rx_en) begin
          if (tick_cnt_q == TICK_LAST) begin
            shift_d    = shift_ext[DATA_WIDTH:1];
            tick_cnt_d = '0;
            if (bit_cnt_q == BIT_LAST) begin
              state_d = STOP;
            end else begin
              bit_cnt_d = bit_cnt_q + 1'b1;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end
      end

      STOP: begin
        if (rx_en) begin
          if (tick_cnt_q == TICK_LAST) begin
            tick_cnt_d = '0;
            if (rxd_s) begin
              rx_data_d  = shift_q;
              rx_valid_d = 1'b1;
              state_d    = IDLE;
            end else begin
              frame_err_d = 1'b1;
              state_d     = BREAK;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end
      end

      BREAK: begin
        // Held-low line after a framing error must go high before a new start.
        if (rxd_s) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d    = IDLE;
        tick_cnt_d = '0;
        bit_cnt_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q      <= 2'b11;
      state_q     <= IDLE;
      tick_cnt_q  <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      sync_q      <= sync_d;
      state_q     <= state_d;
      tick_cnt_q  <= tick_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign rx_busy   = (state_q != IDLE);

endmodule
